// File: rtl/framebuffer_fetch_multi.sv
// framebuffer_fetch_multi
// Pixel fetch engine between the dual-port framebuffer RAM and the panel
// shift-out logic. Each accepted pixel_load_start latches a column/row pair
// and issues one RAM read per scan group (half). Returned words are gathered
// into a packed per-half pixel vector, with half k at
// [k*PIXEL_BITS +: PIXEL_BITS].
//
// Optional build macro FETCH_SHADOW_EN: captures land in shadow registers,
// and pixel_data is loaded from the shadow vector on pixel_commit. Without
// the macro, captures write pixel_data directly and pixel_commit is unused.
//
// Handshake: pixel_load_start is level-sampled at every rising edge. It is
// accepted only in IDLE. A start sampled while busy is dropped, and
// start_overrun is raised for the following cycle. pixel_valid is a
// one-cycle pulse after the final capture. busy covers the whole fetch.
module framebuffer_fetch_multi #(
    parameter int COL_BITS    = 6,
    parameter int ROW_BITS    = 4,
    parameter int HALF_BITS   = 1,
    parameter int PIXEL_BITS  = 16,
    parameter int RAM_LATENCY = 1
) (
    input  logic                                              clk_in,
    input  logic                                              reset,
    input  logic [COL_BITS-1:0]                               column_address,
    input  logic [ROW_BITS-1:0]                               row_address,
    input  logic                                              pixel_load_start,
    input  logic                                              pixel_commit,
    input  logic [PIXEL_BITS-1:0]                             ram_data_in,
    output logic [HALF_BITS+ROW_BITS+COL_BITS-1:0]            ram_address,
    output logic                                              ram_clk_enable,
    output logic                                              ram_reset,
    output logic [(2**HALF_BITS)*PIXEL_BITS-1:0]              pixel_data,
    output logic                                              pixel_valid,
    output logic                                              busy,
    output logic                                              start_overrun
);

    localparam int HALVES   = 2 ** HALF_BITS;
    localparam int TOTAL    = HALVES + RAM_LATENCY;
    // The tick counter has to reach TOTAL-1 without wrapping.
    localparam int CNT_BITS = $clog2(TOTAL + 1);

    localparam logic [CNT_BITS-1:0]  LAST_TICK = CNT_BITS'(TOTAL - 1);
    localparam logic [CNT_BITS-1:0]  LAT_TICKS = CNT_BITS'(RAM_LATENCY);
    localparam logic [HALF_BITS-1:0] LAST_HALF = HALF_BITS'(HALVES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [HALF_BITS-1:0]  half_cnt;   // issue counter: half on the address bus
    logic [CNT_BITS-1:0]   tick;       // edges since the accepting edge
    logic [ROW_BITS-1:0]   row_q;
    logic [COL_BITS-1:0]   col_q;

    // The capture counter is derived from tick and is independent of
    // half_cnt. The word for half k arrives RAM_LATENCY edges after its
    // address, so it is captured once tick has passed that offset.
    logic                  capture_en;
    logic [CNT_BITS-1:0]   cap_idx;

    // The column is mirrored for the panel. Coordinates come from the
    // latched copies, so input changes during a fetch do not affect it.
    assign ram_address    = {half_cnt, row_q, ~col_q};
    assign ram_clk_enable = busy;
    assign ram_reset      = reset;

    // Capture is active only in a busy state, once the latency window is open.
    always_comb begin
        capture_en = 1'b0;
        cap_idx    = tick - LAT_TICKS;
        if ((state != IDLE) && (tick >= LAT_TICKS)) begin
            capture_en = 1'b1;
        end
    end

    // Fetch sequencer: accept, issue halves, drain the RAM pipeline, signal.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            half_cnt      <= '0;
            tick          <= '0;
            row_q         <= '0;
            col_q         <= '0;
            busy          <= 1'b0;
            pixel_valid   <= 1'b0;
            start_overrun <= 1'b0;
        end else begin
            pixel_valid   <= 1'b0;
            start_overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (pixel_load_start) begin
                        row_q    <= row_address;
                        col_q    <= column_address;
                        half_cnt <= '0;
                        tick     <= '0;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    start_overrun <= pixel_load_start;
                    tick          <= tick + CNT_BITS'(1);
                    // Each half stays on the bus for exactly one cycle.
                    if (half_cnt == LAST_HALF) begin
                        state <= DRAIN;
                    end else begin
                        half_cnt <= half_cnt + HALF_BITS'(1);
                    end
                end
                DRAIN: begin
                    start_overrun <= pixel_load_start;
                    // The last capture happens on this edge, so the fetch
                    // ends here and a start at this edge is still dropped.
                    if (tick == LAST_TICK) begin
                        tick        <= '0;
                        busy        <= 1'b0;
                        pixel_valid <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tick <= tick + CNT_BITS'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_SHADOW_EN
    logic [HALVES*PIXEL_BITS-1:0] shadow;

    // Captures fill the shadow vector. A commit copies the pre-capture shadow
    // value, so a commit on a capture edge publishes the older contents.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            shadow     <= '0;
            pixel_data <= '0;
        end else begin
            if (pixel_commit) begin
                pixel_data <= shadow;
            end
            for (int k = 0; k < HALVES; k++) begin
                if (capture_en && (cap_idx == CNT_BITS'(k))) begin
                    shadow[k*PIXEL_BITS +: PIXEL_BITS] <= ram_data_in;
                end
            end
        end
    end
`else
    // Without shadowing, the commit strobe has no function.
    logic unused_commit;
    assign unused_commit = pixel_commit;

    // Captures write the pixel_data slot for the returning half directly.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            pixel_data <= '0;
        end else begin
            for (int k = 0; k < HALVES; k++) begin
                if (capture_en && (cap_idx == CNT_BITS'(k))) begin
                    pixel_data[k*PIXEL_BITS +: PIXEL_BITS] <= ram_data_in;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_framebuffer_fetch_multi.sv
// Bench for framebuffer_fetch_multi. It runs two instances side by side: one
// with default parameters (2 halves, latency 1) and one with 4 halves and
// latency 3. Both instances share the same stimulus. The reference model
// tracks each fetch by its accepting edge and derives busy, valid, overrun,
// address and capture timing arithmetically from that edge. Fetch results
// are queued at acceptance and popped by a separate monitor on pixel_valid.
module tb_framebuffer_fetch_multi;

  localparam int COL_BITS   = 6;
  localparam int ROW_BITS   = 4;
  localparam int PIXEL_BITS = 16;
  localparam int HB_A = 1, LAT_A = 1;
  localparam int HB_B = 2, LAT_B = 3;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  column_address = '0;
  logic [3:0]  row_address = '0;
  logic        pixel_load_start = 1'b0;
  logic        pixel_commit = 1'b0;

  logic [15:0] ram_data_a, ram_data_b;
  logic [10:0] ram_address_a;
  logic [11:0] ram_address_b;
  logic        ram_clk_enable_a, ram_reset_a, pixel_valid_a, busy_a, start_overrun_a;
  logic        ram_clk_enable_b, ram_reset_b, pixel_valid_b, busy_b, start_overrun_b;
  logic [31:0] pixel_data_a;
  logic [63:0] pixel_data_b;

  int checks = 0;
  int errors = 0;
  logic [15:0] salt = 16'h0000;

  always #5 clk_in = ~clk_in;

  framebuffer_fetch_multi #(.COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS), .HALF_BITS(HB_A),
                            .PIXEL_BITS(PIXEL_BITS), .RAM_LATENCY(LAT_A)) dut_a (
    .clk_in(clk_in), .reset(reset), .column_address(column_address),
    .row_address(row_address), .pixel_load_start(pixel_load_start),
    .pixel_commit(pixel_commit), .ram_data_in(ram_data_a), .ram_address(ram_address_a),
    .ram_clk_enable(ram_clk_enable_a), .ram_reset(ram_reset_a), .pixel_data(pixel_data_a),
    .pixel_valid(pixel_valid_a), .busy(busy_a), .start_overrun(start_overrun_a));

  framebuffer_fetch_multi #(.COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS), .HALF_BITS(HB_B),
                            .PIXEL_BITS(PIXEL_BITS), .RAM_LATENCY(LAT_B)) dut_b (
    .clk_in(clk_in), .reset(reset), .column_address(column_address),
    .row_address(row_address), .pixel_load_start(pixel_load_start),
    .pixel_commit(pixel_commit), .ram_data_in(ram_data_b), .ram_address(ram_address_b),
    .ram_clk_enable(ram_clk_enable_b), .ram_reset(ram_reset_b), .pixel_data(pixel_data_b),
    .pixel_valid(pixel_valid_b), .busy(busy_b), .start_overrun(start_overrun_b));

  // RAM contents: the address xor a per-run salt.
  function automatic logic [15:0] ram_fn(input int addr);
    return 16'(addr) ^ salt;
  endfunction

  // RAM read pipelines: data is valid LAT edges after the address is presented.
  logic [15:0] pipe_a[LAT_A];
  logic [15:0] pipe_b[LAT_B];
  always @(posedge clk_in) begin
    pipe_a[0] <= ram_fn(int'(ram_address_a));
    for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b[0] <= ram_fn(int'(ram_address_b));
    for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign ram_data_a = pipe_a[LAT_A-1];
  assign ram_data_b = pipe_b[LAT_B-1];

  // Uniform views of both instances, indexed by instance number.
  logic [63:0] a_data[2];
  logic [11:0] a_addr[2];
  logic        a_busy[2], a_cke[2], a_rst[2], a_valid[2], a_ovr[2];
  assign a_data[0] = 64'(pixel_data_a);
  assign a_data[1] = pixel_data_b;
  assign a_addr[0] = 12'(ram_address_a);
  assign a_addr[1] = ram_address_b;
  assign a_busy[0] = busy_a;
  assign a_busy[1] = busy_b;
  assign a_cke[0] = ram_clk_enable_a;
  assign a_cke[1] = ram_clk_enable_b;
  assign a_rst[0] = ram_reset_a;
  assign a_rst[1] = ram_reset_b;
  assign a_valid[0] = pixel_valid_a;
  assign a_valid[1] = pixel_valid_b;
  assign a_ovr[0] = start_overrun_a;
  assign a_ovr[1] = start_overrun_b;

  // Reference model state.
  int hh[2] = '{2, 4};
  int ll[2] = '{LAT_A, LAT_B};
  int n = 0;
  int acc[2];
  int row_l[2], col_l[2];
  logic [15:0] m_out[2][4];
  logic [15:0] m_shadow[2][4];
  logic e_busy[2], e_valid[2], e_ovr[2];
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int addr_of(input int k, input int r, input int c);
    return (k << (ROW_BITS + COL_BITS)) | (r << COL_BITS) | ((~c) & 63);
  endfunction

  function automatic logic [63:0] exp_vec(input int d, input int r, input int c);
    logic [63:0] v = '0;
    for (int k = 0; k < hh[d]; k++) v[k*16 +: 16] = ram_fn(addr_of(k, r, c));
    return v;
  endfunction

  function automatic logic [63:0] pack_out(input int d);
    logic [63:0] v = '0;
    for (int k = 0; k < hh[d]; k++) v[k*16 +: 16] = m_out[d][k];
    return v;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      acc[d] = -1000;
      e_busy[d] = 1'b0;
      e_valid[d] = 1'b0;
      e_ovr[d] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        m_out[d][k] = '0;
        m_shadow[d][k] = '0;
      end
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  initial model_clear();

  // Model update at each rising edge, from the inputs sampled at that edge.
  always @(posedge clk_in) begin
    n++;
    if (reset) begin
      model_clear();
    end else begin
      for (int d = 0; d < 2; d++) begin
        int t;
        logic busy_before;
        t = hh[d] + ll[d];
        busy_before = (n - 1 >= acc[d]) && (n - 1 < acc[d] + t);
        e_ovr[d] = pixel_load_start && busy_before;
        if (pixel_load_start && !busy_before) begin
          acc[d] = n;
          row_l[d] = int'(row_address);
          col_l[d] = int'(column_address);
          if (d == 0) exp_q0.push_back(exp_vec(0, row_l[d], col_l[d]));
          else exp_q1.push_back(exp_vec(1, row_l[d], col_l[d]));
        end
        e_valid[d] = (n == acc[d] + t);
        e_busy[d] = (n >= acc[d]) && (n < acc[d] + t);
`ifdef FETCH_SHADOW_EN
        if (pixel_commit) begin
          for (int k = 0; k < 4; k++) m_out[d][k] = m_shadow[d][k];
        end
`endif
        for (int k = 0; k < hh[d]; k++) begin
          if (n == acc[d] + k + ll[d] + 1) begin
`ifdef FETCH_SHADOW_EN
            m_shadow[d][k] = ram_fn(addr_of(k, row_l[d], col_l[d]));
`else
            m_out[d][k] = ram_fn(addr_of(k, row_l[d], col_l[d]));
`endif
          end
        end
      end
    end
  end

  // Per-cycle output check, sampled after the edge.
  always @(posedge clk_in) begin
    #2;
    if (reset) begin
      model_clear();
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rst_busy[%0d]", d), 64'(a_busy[d]), 64'(0));
        chk($sformatf("rst_cke[%0d]", d), 64'(a_cke[d]), 64'(0));
        chk($sformatf("rst_valid[%0d]", d), 64'(a_valid[d]), 64'(0));
        chk($sformatf("rst_ovr[%0d]", d), 64'(a_ovr[d]), 64'(0));
        chk($sformatf("rst_data[%0d]", d), a_data[d], 64'(0));
        chk($sformatf("rst_addr[%0d]", d), 64'(a_addr[d]), 64'(12'h03F));
        chk($sformatf("rst_ramrst[%0d]", d), 64'(a_rst[d]), 64'(1));
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("busy[%0d]", d), 64'(a_busy[d]), 64'(e_busy[d]));
        chk($sformatf("cke[%0d]", d), 64'(a_cke[d]), 64'(e_busy[d]));
        chk($sformatf("valid[%0d]", d), 64'(a_valid[d]), 64'(e_valid[d]));
        chk($sformatf("overrun[%0d]", d), 64'(a_ovr[d]), 64'(e_ovr[d]));
        chk($sformatf("data[%0d]", d), a_data[d], pack_out(d));
        chk($sformatf("ramrst[%0d]", d), 64'(a_rst[d]), 64'(0));
        if ((n >= acc[d]) && (n < acc[d] + hh[d]))
          chk($sformatf("addr[%0d]", d), 64'(a_addr[d]),
              64'(addr_of(n - acc[d], row_l[d], col_l[d])));
      end
    end
  end

  // Scoreboard monitor: each pixel_valid retires the oldest accepted fetch.
  always @(posedge clk_in) begin
    logic [63:0] exp;
    #3;
    if (!reset) begin
      if (pixel_valid_a) begin
        if (exp_q0.size() == 0) chk("sb_underflow_a", 64'(1), 64'(0));
        else begin
          exp = exp_q0.pop_front();
`ifndef FETCH_SHADOW_EN
          chk("sb_fetch_a", a_data[0], exp);
`endif
        end
      end
      if (pixel_valid_b) begin
        if (exp_q1.size() == 0) chk("sb_underflow_b", 64'(1), 64'(0));
        else begin
          exp = exp_q1.pop_front();
`ifndef FETCH_SHADOW_EN
          chk("sb_fetch_b", a_data[1], exp);
`endif
        end
      end
    end
  end

  // Stimulus.
  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);

    // Directed fetch at column 5, row 3, RAM returning its address.
    column_address = 6'd5;
    row_address = 4'd3;
    pixel_load_start = 1'b1;
    @(negedge clk_in);
    pixel_load_start = 1'b0;
    column_address = 6'd63;
    row_address = 4'd15;
    repeat (10) @(negedge clk_in);

    // Commit on the final capture edge of the default instance, then later.
    column_address = 6'd17;
    row_address = 4'd9;
    pixel_load_start = 1'b1;
    @(negedge clk_in);
    pixel_load_start = 1'b0;
    repeat (2) @(negedge clk_in);
    pixel_commit = 1'b1;
    @(negedge clk_in);
    pixel_commit = 1'b0;
    repeat (6) @(negedge clk_in);
    pixel_commit = 1'b1;
    @(negedge clk_in);
    pixel_commit = 1'b0;
    repeat (4) @(negedge clk_in);

    // Start held high continuously, with coordinates changing every cycle.
    pixel_load_start = 1'b1;
    repeat (24) begin
      column_address = 6'($urandom);
      row_address = 4'($urandom);
      @(negedge clk_in);
    end
    pixel_load_start = 1'b0;
    repeat (10) @(negedge clk_in);

    salt = 16'($urandom);

    // Reset at E2 of a fetch, then a normal fetch after release.
    pixel_load_start = 1'b1;
    @(negedge clk_in);
    pixel_load_start = 1'b0;
    @(negedge clk_in);
    @(posedge clk_in);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    column_address = 6'($urandom);
    row_address = 4'($urandom);
    pixel_load_start = 1'b1;
    @(negedge clk_in);
    pixel_load_start = 1'b0;
    repeat (12) @(negedge clk_in);

    // Randomized traffic.
    repeat (400) begin
      pixel_load_start = ($urandom_range(0, 99) < 35);
      pixel_commit = ($urandom_range(0, 3) == 0);
      column_address = 6'($urandom);
      row_address = 4'($urandom);
      @(negedge clk_in);
    end
    pixel_load_start = 1'b0;
    pixel_commit = 1'b0;
    repeat (15) @(negedge clk_in);

    chk("pending_a", 64'(exp_q0.size()), 64'(0));
    chk("pending_b", 64'(exp_q1.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
